// File: rtl/rom_loader_pipe.sv
// rom_loader_pipe: copies a programmable number of words from Flash to SDRAM through a small FIFO
module rom_loader_pipe #(
  parameter int DW          = 16,
  parameter int FL_AW       = 23,
  parameter int RAM_AW      = 25,
  parameter int LEN_W       = 23,
  parameter int FIFO_DEPTH  = 4,
  parameter int SRC_BASE    = 0,
  parameter int DST_BASE    = 0,
  parameter int AUTO_START  = 1,
  parameter int DEFAULT_LEN = 4194304,
  parameter int BYTE_SWAP   = 0
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              istart,
  input  logic [LEN_W-1:0]  ilength,
  input  logic              iabort,
  output logic              oloading,
  output logic              odone,
  output logic              oaborted,
  output logic [15:0]       ochecksum,
  input  logic              irom_load_wait,
  output logic              orom_load_wr,
  output logic [RAM_AW-1:0] oram_addr,
  output logic [DW-1:0]     oram_wrdata,
  output logic [FL_AW-1:0]  ofl_addr,
  input  logic [DW-1:0]     ifl_data,
  output logic              ofl_req,
  input  logic              ifl_ack
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {W_IDLE, W_STROBE, W_WAIT} wstate_t;
  state_t state, state_nx;
  wstate_t wstate, wstate_nx;
  logic booted, pend;
  logic [LEN_W-1:0] len, rd_cnt, wr_cnt, start_len;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [DW-1:0] head, word;
  logic auto_go, start, go, fl_done, issue, push, pop, drain_ok;
  assign auto_go   = AUTO_START != 0 && !booted;
  assign start     = auto_go || (istart && (state == IDLE || state == DONE));
  assign start_len = auto_go ? LEN_W'(DEFAULT_LEN) : ilength;
  assign go        = state == RUN && !iabort;
  assign fl_done   = pend && (ifl_ack == ofl_req);
  assign issue     = go && !pend && rd_cnt < len && count < FULL;
  assign push      = fl_done && state == RUN;
  assign pop       = go && wstate == W_IDLE && count != '0 && !irom_load_wait;
  assign drain_ok  = state == DRAIN && !pend && wstate == W_IDLE;
  assign head      = mem[rd_ptr];
  assign word      = BYTE_SWAP != 0 ? {head[DW/2-1:0], head[DW-1:DW/2]} : head;
  assign oloading     = state == RUN || state == DRAIN;
  assign odone        = state == DONE;
  assign orom_load_wr = wstate == W_STROBE;
  // control and write-engine state registers
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state  <= IDLE;
      wstate <= W_IDLE;
    end else begin
      state  <= state_nx;
      wstate <= wstate_nx;
    end
  end
  // next-state: abort beats completion in RUN; start only from IDLE/DONE
  always_comb begin
    state_nx = state;
    wstate_nx = wstate;
    state_nx = start ? (start_len == '0 ? DONE : RUN)
             : (state == RUN && iabort) ? DRAIN
             : (state == RUN && wr_cnt == len && wstate == W_IDLE) ? DONE
             : drain_ok ? DONE : state;
    wstate_nx = pop ? W_STROBE
              : wstate == W_STROBE ? W_WAIT
              : (wstate == W_WAIT && !irom_load_wait) ? W_IDLE : wstate;
  end
  // counters, Flash handshake, SDRAM write registers and checksum
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      booted      <= 1'b0;
      pend        <= 1'b0;
      len         <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      oaborted    <= 1'b0;
      ochecksum   <= '0;
      oram_addr   <= '0;
      oram_wrdata <= '0;
      ofl_addr    <= '0;
      ofl_req     <= 1'b0;
    end else begin
      booted <= 1'b1;
      if (start) begin
        len       <= start_len;
        rd_cnt    <= '0;
        wr_cnt    <= '0;
        ochecksum <= '0;
        oaborted  <= 1'b0;
      end
      if (issue) begin
        ofl_addr <= FL_AW'(SRC_BASE) + (FL_AW'(rd_cnt) << 1);
        ofl_req  <= ~ifl_ack;
        pend     <= 1'b1;
      end
      if (fl_done) pend <= 1'b0;
      if (push) rd_cnt <= rd_cnt + LEN_W'(1);
      if (pop) begin
        oram_addr   <= RAM_AW'(DST_BASE) + (RAM_AW'(wr_cnt) << 1);
        oram_wrdata <= word;
      end
      if (wstate == W_STROBE) ochecksum <= ochecksum + 16'(oram_wrdata);
      if (wstate == W_WAIT && !irom_load_wait) wr_cnt <= wr_cnt + LEN_W'(1);
      if (drain_ok) oaborted <= 1'b1;
    end
  end
  // word FIFO; a drain flush discards whatever was read ahead
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (drain_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ifl_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_rom_loader_pipe.sv
// tb_rom_loader_pipe: scoreboard bench with an auto-start instance and a byte-swap instance
module tb_rom_loader_pipe;
  typedef struct packed {logic [24:0] addr; logic [15:0] data;} wr_t;
  logic clk = 0, ireset_n = 0;
  logic istart_a = 0, iabort_a = 0, irom_load_wait_a = 0, ifl_ack_a = 0;
  logic [22:0] ilength_a = 0;
  logic [15:0] ifl_data_a = 0;
  logic oloading_a, odone_a, oaborted_a, orom_load_wr_a, ofl_req_a;
  logic [15:0] ochecksum_a, oram_wrdata_a;
  logic [24:0] oram_addr_a;
  logic [22:0] ofl_addr_a;
  logic istart_b = 0, iabort_b = 0, irom_load_wait_b = 0, ifl_ack_b = 0;
  logic [22:0] ilength_b = 0;
  logic [15:0] ifl_data_b = 0;
  logic oloading_b, odone_b, oaborted_b, orom_load_wr_b, ofl_req_b;
  logic [15:0] ochecksum_b, oram_wrdata_b;
  logic [24:0] oram_addr_b;
  logic [22:0] ofl_addr_b;
  wr_t qa[$], qb[$];
  wr_t ea, eb;
  int total = 0, bad = 0, sa = 0, sb = 0, reads_a = 0, reads_b = 0;
  logic force_wait_a = 0;
  int fa_cnt = 0, fb_cnt = 0, hold_a = 0;
  logic fa_busy = 0, fb_busy = 0;
  logic [22:0] fa_addr = 0, fb_addr = 0;

  rom_loader_pipe #(.DW(16), .FL_AW(23), .RAM_AW(25), .LEN_W(23), .FIFO_DEPTH(4), .SRC_BASE(0),
    .DST_BASE(0), .AUTO_START(1), .DEFAULT_LEN(8), .BYTE_SWAP(0)) dut_a (
    .iclk(clk), .ireset_n(ireset_n), .istart(istart_a), .ilength(ilength_a), .iabort(iabort_a),
    .oloading(oloading_a), .odone(odone_a), .oaborted(oaborted_a), .ochecksum(ochecksum_a),
    .irom_load_wait(irom_load_wait_a), .orom_load_wr(orom_load_wr_a), .oram_addr(oram_addr_a),
    .oram_wrdata(oram_wrdata_a), .ofl_addr(ofl_addr_a), .ifl_data(ifl_data_a), .ofl_req(ofl_req_a),
    .ifl_ack(ifl_ack_a));

  rom_loader_pipe #(.DW(16), .FL_AW(23), .RAM_AW(25), .LEN_W(23), .FIFO_DEPTH(4), .SRC_BASE(0),
    .DST_BASE('h100), .AUTO_START(0), .DEFAULT_LEN(8), .BYTE_SWAP(1)) dut_b (
    .iclk(clk), .ireset_n(ireset_n), .istart(istart_b), .ilength(ilength_b), .iabort(iabort_b),
    .oloading(oloading_b), .odone(odone_b), .oaborted(oaborted_b), .ochecksum(ochecksum_b),
    .irom_load_wait(irom_load_wait_b), .orom_load_wr(orom_load_wr_b), .oram_addr(oram_addr_b),
    .oram_wrdata(oram_wrdata_b), .ofl_addr(ofl_addr_b), .ifl_data(ifl_data_b), .ofl_req(ofl_req_b),
    .ifl_ack(ifl_ack_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a();
    for (int i = 0; i < 8; i++) qa.push_back('{addr: 25'(2 * i), data: 16'h1100 + 16'(i)});
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    logic prev;
    n = 0;
    prev = oloading_a;
    while (!odone_a && n < 2000) begin
      step();
      n++;
      if (odone_a) chk({tag, "_load_fall"}, {30'd0, prev, oloading_a}, 32'd2);
      prev = oloading_a;
    end
    chk({tag, "_done"}, 32'(odone_a), 32'd1);
  endtask

  // Flash A: 3-cycle ack latency, word n = 0x1100+n; SDRAM A busy for 2 cycles after each strobe
  always @(posedge clk) begin
    #1;
    if (!ireset_n) begin
      fa_busy = 0;
      ifl_ack_a = 0;
      hold_a = 0;
      irom_load_wait_a = force_wait_a;
    end else begin
      if (fa_busy) begin
        fa_cnt--;
        if (fa_cnt == 0) begin
          ifl_data_a = 16'h1100 + 16'(fa_addr >> 1);
          ifl_ack_a = ofl_req_a;
          fa_busy = 0;
          reads_a++;
        end
      end else if (ofl_req_a != ifl_ack_a) begin
        fa_busy = 1;
        fa_cnt = 3;
        fa_addr = ofl_addr_a;
      end
      hold_a = orom_load_wr_a ? 3 : (hold_a > 0 ? hold_a - 1 : 0);
      irom_load_wait_a = force_wait_a || hold_a > 0;
    end
  end

  // Flash B: same latency, word n = 0xA1B2+n; SDRAM B never busy
  always @(posedge clk) begin
    #1;
    if (!ireset_n) begin
      fb_busy = 0;
      ifl_ack_b = 0;
    end else if (fb_busy) begin
      fb_cnt--;
      if (fb_cnt == 0) begin
        ifl_data_b = 16'hA1B2 + 16'(fb_addr >> 1);
        ifl_ack_b = ofl_req_b;
        fb_busy = 0;
        reads_b++;
      end
    end else if (ofl_req_b != ifl_ack_b) begin
      fb_busy = 1;
      fb_cnt = 3;
      fb_addr = ofl_addr_b;
    end
  end

  always @(negedge clk) begin
    if (ireset_n && orom_load_wr_a) begin
      sa++;
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_wr: strobe at addr %h data %h, no write expected", oram_addr_a, oram_wrdata_a);
      end else begin
        ea = qa.pop_front();
        chk("a_wr_addr", 32'(oram_addr_a), 32'(ea.addr));
        chk("a_wr_data", 32'(oram_wrdata_a), 32'(ea.data));
      end
    end
  end

  always @(negedge clk) begin
    if (ireset_n && orom_load_wr_b) begin
      sb++;
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_wr: strobe at addr %h data %h, no write expected", oram_addr_b, oram_wrdata_b);
      end else begin
        eb = qb.pop_front();
        chk("b_wr_addr", 32'(oram_addr_b), 32'(eb.addr));
        chk("b_wr_data", 32'(oram_wrdata_b), 32'(eb.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, r0, n;
    logic [15:0] cs;
    repeat (3) step();
    chk("a_reset_ctl", {27'd0, oloading_a, odone_a, oaborted_a, orom_load_wr_a, ofl_req_a}, 32'd0);
    chk("a_reset_ram_addr", 32'(oram_addr_a), 32'd0);
    chk("a_reset_fl_addr", 32'(ofl_addr_a), 32'd0);
    chk("a_reset_csum", 32'(ochecksum_a), 32'd0);
    chk("b_reset_ctl", {27'd0, oloading_b, odone_b, oaborted_b, orom_load_wr_b, ofl_req_b}, 32'd0);
    // auto-start copy of 8 words
    push_a();
    ireset_n = 1;
    step();
    chk("auto_loading", 32'(oloading_a), 32'd1);
    wait_done_a("auto");
    chk("auto_csum", 32'(ochecksum_a), 32'h881C);
    chk("auto_aborted", 32'(oaborted_a), 32'd0);
    chk("auto_q_empty", qa.size(), 32'd0);
    chk("auto_writes", sa, 32'd8);
    chk("b_idle_no_req", {30'd0, ofl_req_b, oloading_b}, 32'd0);
    // backpressure: SDRAM busy 40 cycles, reads stop at FIFO depth; start while RUN is ignored
    push_a();
    force_wait_a = 1;
    step();
    r0 = reads_a;
    s0 = sa;
    istart_a = 1;
    ilength_a = 8;
    step();
    istart_a = 0;
    repeat (5) step();
    istart_a = 1;
    ilength_a = 2;
    step();
    istart_a = 0;
    repeat (33) step();
    chk("bp_reads", reads_a - r0, 32'd4);
    chk("bp_no_writes", sa - s0, 32'd0);
    force_wait_a = 0;
    wait_done_a("bp");
    chk("bp_csum", 32'(ochecksum_a), 32'h881C);
    chk("bp_q_empty", qa.size(), 32'd0);
    chk("bp_reads_total", reads_a - r0, 32'd8);
    // zero-length start on the non-auto instance
    step();
    istart_b = 1;
    ilength_b = 0;
    step();
    istart_b = 0;
    chk("zero_done", {30'd0, odone_b, oloading_b}, 32'd2);
    repeat (5) step();
    chk("zero_no_req", 32'(ofl_req_b), 32'd0);
    chk("zero_no_wr", sb + reads_b, 32'd0);
    chk("zero_csum", 32'(ochecksum_b), 32'd0);
    // byte swap with DST_BASE 0x100
    qb.push_back('{addr: 25'h100, data: 16'hB2A1});
    qb.push_back('{addr: 25'h102, data: 16'hB3A1});
    istart_b = 1;
    ilength_b = 2;
    step();
    istart_b = 0;
    n = 0;
    while (!odone_b && n < 500) begin
      step();
      n++;
    end
    chk("swap_done", 32'(odone_b), 32'd1);
    chk("swap_csum", 32'(ochecksum_b), 32'h6642);
    chk("swap_q_empty", qb.size(), 32'd0);
    // abort after 3 writes, with a Flash request outstanding and SDRAM busy
    push_a();
    s0 = sa;
    istart_a = 1;
    ilength_a = 8;
    step();
    istart_a = 0;
    n = 0;
    while (!(sa - s0 >= 3 && ofl_req_a != ifl_ack_a && irom_load_wait_a) && n < 400) begin
      step();
      n++;
    end
    chk("abort_window", 32'(n < 400), 32'd1);
    iabort_a = 1;
    r0 = sa - s0;
    step();
    iabort_a = 0;
    wait_done_a("abort");
    chk("abort_flag", 32'(oaborted_a), 32'd1);
    chk("abort_no_more_wr", sa - s0, r0);
    chk("abort_ack_absorbed", 32'(ofl_req_a == ifl_ack_a), 32'd1);
    cs = 0;
    for (int i = 0; i < r0; i++) cs += 16'h1100 + 16'(i);
    chk("abort_csum", 32'(ochecksum_a), 32'(cs));
    chk("abort_q_left", qa.size(), 32'(8 - r0));
    qa.delete();
    // asynchronous reset mid-copy, then auto-start from DST_BASE again
    push_a();
    s0 = sa;
    istart_a = 1;
    ilength_a = 8;
    step();
    istart_a = 0;
    n = 0;
    while (sa - s0 < 2 && n < 400) begin
      step();
      n++;
    end
    #2;
    ireset_n = 0;
    #1;
    chk("mid_reset_ctl", {27'd0, oloading_a, odone_a, oaborted_a, orom_load_wr_a, ofl_req_a}, 32'd0);
    chk("mid_reset_addr", 32'(oram_addr_a) | 32'(ofl_addr_a), 32'd0);
    chk("mid_reset_data_csum", {oram_wrdata_a, ochecksum_a}, 32'd0);
    qa.delete();
    repeat (3) step();
    push_a();
    ireset_n = 1;
    step();
    wait_done_a("restart");
    chk("restart_csum", 32'(ochecksum_a), 32'h881C);
    chk("restart_q_empty", qa.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
